// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell driven one bit per clock by serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: streams operands LSB-first through one full_adder, one bit per clock,
// and presents the assembled sum/cout with a single-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_if.slave    bus
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cout_q;
  logic             done_q;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (a_sh[0], b_sh[0], carry, fa_sum, fa_carry);

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sum_sh <= sum_next;
          carry  <= fa_carry;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum_q  <= sum_next;
            cout_q <= fa_carry;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_SHIFT);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder that sits directly upstream of the team's full_adder cell and drives it one bit per clock. It accepts two WIDTH-bit operands plus a carry-in on a start pulse. It streams LSB-first operand bits into a single full_adder instance and registers the carry between cycles. It assembles the sum in a shift register and presents sum/cout with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  single-cycle pulse; sum/cout are valid
sum  output  WIDTH  result; held until the next completion
cout  output  1  final carry-out; held with sum

Behaviour:
- Reset: any edge with rst_n=0 does the following, overriding all other activity including mid-operation:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shifters, carry flop, sum shifter and bit counter all cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; state->SHIFT.
  - start=0: remain in IDLE.
- SHIFT (edges E1..E_WIDTH), each edge:
  - full_adder inputs are a_sh[0], b_sh[0], carry.
  - Its sum bit enters the MSB of the sum shifter, which shifts right.
  - carry<=full_adder carry.
  - a_sh and b_sh shift right (zero fill).
  - cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1 (edge E_WIDTH): sum<=completed shifter value, cout<=final carry, done<=1, state->DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation); state->SHIFT.
  - Otherwise state->IDLE.
  - done is cleared at the next edge in either case.
- busy = (state==SHIFT), registered/decoded from state.
  - busy=1 between edges E0 and E_WIDTH.
- Latency: done is visible in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after start is sampled. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no reload, no effect on the result.
- sum/cout change only at completion; they hold their value through IDLE and any following SHIFT.
- Arithmetic is modulo 2^WIDTH; the carry out of bit WIDTH-1 goes to cout.
- cnt width is $clog2(WIDTH). Comparison against WIDTH-1 must be correct for non-power-of-2 WIDTH (e.g. 5).
- Operand inputs may change freely after the accepting edge.
- No X on any output after the first reset edge.

Decomposition:
- Shared package/header serial_defs: state encodings ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10. Default WIDTH constant.
- One sub-module: the existing full_adder, instantiated once with positional order (a, b, c, sum, carry).
- Counter, shifters and FSM live in serial_adder itself.

Test Plan:
1. Reset, then start with a=8'h00, b=8'h00, cin=0:
   - done pulses exactly 9 edges after start.
   - sum=8'h00, cout=0; busy high for 8 cycles.
2. a=8'hFF, b=8'h01, cin=0 (carry ripples through all bits):
   - sum=8'h00, cout=1.
   - Then a=8'd100, b=8'd27, cin=0 -> sum=8'd127, cout=0.
3. a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
   - Start re-asserted with a=8'h01, b=8'h01 during SHIFT is ignored; result unchanged.
4. rst_n=0 for one edge after the 3rd shift of a=8'hFF, b=8'hFF:
   - Next cycle busy=0, done=0, sum=0, cout=0.
   - A fresh start of 8'h03+8'h04 -> sum=8'h07.
5. Back-to-back: start held high in the DONE cycle with new operands 8'h80+8'h80:
   - Second done arrives 9 edges later with sum=8'h00, cout=1.
   - First result held until then.
6. WIDTH=2 exhaustive: all 32 (a, b, cin) combinations compared against a+b+cin.
   - WIDTH=5 spot check: 5'h1F + 5'h01 -> sum=0, cout=1.
